// File: rtl/alu_result_collector.sv
// ALU result collector: tracks ALU issues, captures results one cycle later, queues them.
// Optional RESULT_STATS_EN adds saturating push/drop counters.
module alu_result_collector #(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 4
`ifdef RESULT_STATS_EN
   ,parameter int CNT_WIDTH = 8
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_en,
   input  logic                       issue_control,
   input  logic [DATA_WIDTH:0]        alu_y,
   output logic                       issue_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_flag,
   output logic                       out_op,
   output logic [$clog2(DEPTH):0]     count
`ifdef RESULT_STATS_EN
   ,output logic [CNT_WIDTH-1:0]      stat_pushed
   ,output logic [CNT_WIDTH-1:0]      stat_dropped
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_WIDTH + 2;

   logic            r_pend_v;
   logic            r_pend_op;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [EW-1:0]   r_mem [DEPTH];
   logic [EW-1:0]   r_hold;

   logic [CW:0]     w_occ;
   logic            w_accept;
   logic            w_push;
   logic            w_pop;
   logic            w_valid;
   logic [EW-1:0]   w_head;

   // Occupancy counts the in-flight result so a slot is reserved at issue time
   assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_pend_v};
   assign issue_ready = w_occ < (CW+1)'(DEPTH);
   assign w_accept    = issue_en & issue_ready;
   assign w_push      = r_pend_v;
   assign w_valid     = r_count != '0;
   assign w_pop       = w_valid & out_ready;
   assign w_head      = r_mem[r_rptr];

   assign out_valid = w_valid;
   assign count     = r_count;
   assign out_op    = w_valid ? w_head[EW-1]           : r_hold[EW-1];
   assign out_flag  = w_valid ? w_head[DATA_WIDTH]     : r_hold[DATA_WIDTH];
   assign out_data  = w_valid ? w_head[DATA_WIDTH-1:0] : r_hold[DATA_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_v  <= 1'b0;
         r_pend_op <= 1'b0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_hold    <= '0;
      end else begin
         r_pend_v <= w_accept;
         if (w_accept)
            r_pend_op <= issue_control;
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
            r_hold <= w_head;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= {r_pend_op, alu_y};
   end

   a_no_full_push: assert property (@(posedge clk) disable iff (rst)
      !(w_push && r_count == CW'(DEPTH)));

`ifdef RESULT_STATS_EN
   logic [CNT_WIDTH-1:0] r_stat_pushed;
   logic [CNT_WIDTH-1:0] r_stat_dropped;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_pushed  <= '0;
         r_stat_dropped <= '0;
      end else begin
         if (w_push && r_stat_pushed != '1)
            r_stat_pushed <= r_stat_pushed + 1'b1;
         if (issue_en && !issue_ready && r_stat_dropped != '1)
            r_stat_dropped <= r_stat_dropped + 1'b1;
      end
   end

   assign stat_pushed  = r_stat_pushed;
   assign stat_dropped = r_stat_dropped;
`endif

endmodule
